// File: rtl/mul_add_stream_pkg.sv
// Shared constants and helpers for the mul_add_stream block.
package mul_add_stream_pkg;

  // Mode encoding on the mode input and in the S1 register.
  localparam logic MODE_FUSED = 1'b0;
  localparam logic MODE_ACC   = 1'b1;

  // Number of pipeline stages (S1 product, S2 result).
  localparam int STAGES = 2;

  // Low bit of lane `lane` inside a flat LANES*width bus.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/mul_add_stream_lane.sv
// One lane of the datapath: S1 product/addend, S2 result and the lane accumulator.
module mul_add_stream_lane
  import mul_add_stream_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s1_load,
  input  logic             s2_load,
  input  logic             s1_mode,
  input  logic             s1_clr,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] res
);

  logic [WIDTH-1:0] prod_q;
  logic [WIDTH-1:0] z_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] fused;

  // Result candidates; widths truncate so overflow is dropped silently.
  assign acc_base = s1_clr ? '0 : acc_q;
  assign acc_next = acc_base + prod_q;
  assign fused    = prod_q + z_q;
  assign res      = res_q;

  // S1: capture the low WIDTH bits of the product and the addend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      z_q    <= '0;
    end else if (s1_load) begin
      prod_q <= x * y;
      z_q    <= z;
    end
  end

  // S2: register the result; the accumulator moves only when an acc beat lands here,
  // so a stalled beat sitting in S1 is never counted twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      acc_q <= '0;
    end else if (s2_load) begin
      if (s1_mode == MODE_ACC) begin
        res_q <= acc_next;
        acc_q <= acc_next;
      end else begin
        res_q <= fused;
      end
    end
  end

endmodule

// File: rtl/mul_add_stream.sv
// Two-stage multiply-add stream: shared valid/ready control over LANES datapath lanes.
module mul_add_stream
  import mul_add_stream_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] x,
  input  logic [LANES*WIDTH-1:0] y,
  input  logic [LANES*WIDTH-1:0] z,
  input  logic                   mode,
  input  logic                   acc_clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   busy
);

  // vld_pipe[1] = S1 holds a beat, vld_pipe[2] = S2 holds a beat.
  logic [STAGES:1] vld_pipe;
  logic            s1_mode;
  logic            s1_clr;
  logic            s1_load;
  logic            s2_load;
  logic            s1_free;
  logic            s2_free;

  // Stage advance rules; in_ready depends only on state and out_ready.
  assign s2_free   = !vld_pipe[2] || out_ready;
  assign s2_load   = vld_pipe[1] && s2_free;
  assign s1_free   = !vld_pipe[1] || s2_load;
  assign in_ready  = s1_free;
  assign s1_load   = in_valid && in_ready;
  assign out_valid = vld_pipe[2];
  assign busy      = |vld_pipe;

  // Valid bits: each stage refills whenever it is empty or handing its beat on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      if (s1_free) vld_pipe[1] <= in_valid;
      if (s2_free) vld_pipe[2] <= vld_pipe[1];
    end
  end

  // Per-beat control carried alongside the S1 product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_mode <= MODE_FUSED;
      s1_clr  <= 1'b0;
    end else if (s1_load) begin
      s1_mode <= mode;
      s1_clr  <= acc_clr;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mul_add_stream_lane #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .s1_load (s1_load),
      .s2_load (s2_load),
      .s1_mode (s1_mode),
      .s1_clr  (s1_clr),
      .x       (x[lane_lsb(i, WIDTH) +: WIDTH]),
      .y       (y[lane_lsb(i, WIDTH) +: WIDTH]),
      .z       (z[lane_lsb(i, WIDTH) +: WIDTH]),
      .res     (out_data[lane_lsb(i, WIDTH) +: WIDTH])
    );
  end

endmodule

// File: tb/tb_mul_add_stream.sv
// Directed + random bench for mul_add_stream with a queue-based reference model.
module tb_mul_add_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=32, LANES=1 (main target, scoreboarded)
  logic        a_in_valid = 0, a_in_ready, a_mode = 0, a_clr = 0;
  logic        a_out_valid, a_out_ready = 1, a_busy;
  logic [31:0] a_x = 0, a_y = 0, a_z = 0, a_out;
  // Instance B: WIDTH=8
  logic        b_in_valid = 0, b_in_ready, b_mode = 0, b_clr = 0, b_out_valid, b_busy;
  logic [7:0]  b_x = 0, b_y = 0, b_z = 0, b_out;
  // Instance C: WIDTH=16, LANES=4
  logic        c_in_valid = 0, c_in_ready, c_out_valid, c_busy;
  logic [63:0] c_x = 0, c_y = 0, c_z = 0, c_out;

  mul_add_stream #(.WIDTH(32), .LANES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .x(a_x), .y(a_y), .z(a_z), .mode(a_mode), .acc_clr(a_clr),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out), .busy(a_busy));
  mul_add_stream #(.WIDTH(8), .LANES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .x(b_x), .y(b_y), .z(b_z), .mode(b_mode), .acc_clr(b_clr),
    .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_out), .busy(b_busy));
  mul_add_stream #(.WIDTH(16), .LANES(4)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .x(c_x), .y(c_y), .z(c_z), .mode(1'b0), .acc_clr(1'b0),
    .out_valid(c_out_valid), .out_ready(1'b1), .out_data(c_out), .busy(c_busy));

  int checks = 0;
  int errors = 0;

  // Reference model state for instance A
  logic [31:0] acc_m = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got[$];
  logic        stall_prev = 0;
  logic [31:0] held = 0;
  // Samples taken at the last negedge
  logic        a_ov_s, a_ir_s, a_acc_s, b_ov_s, c_ov_s;
  logic [31:0] a_od_s;
  logic [7:0]  b_od_s;
  logic [63:0] c_od_s;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample and score at negedge, then step to just after the next posedge.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    a_acc_s = a_in_valid && a_in_ready;
    if (a_acc_s) begin
      if (a_mode == 1'b0) e = a_x * a_y + a_z;
      else begin
        acc_m = (a_clr ? 32'd0 : acc_m) + a_x * a_y;
        e = acc_m;
      end
      exp_q.push_back(e);
    end
    if (stall_prev) begin
      chk("hold_valid", a_out_valid, 1'b1);
      chk("hold_data", a_out, held);
    end
    if (a_out_valid && a_out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", a_out_valid, 1'b0);
      else begin
        e = exp_q.pop_front();
        chk("a_data", a_out, e);
        got.push_back(a_out);
      end
    end
    stall_prev = a_out_valid && !a_out_ready;
    held   = a_out;
    a_ov_s = a_out_valid; a_od_s = a_out; a_ir_s = a_in_ready;
    b_ov_s = b_out_valid; b_od_s = b_out;
    c_ov_s = c_out_valid; c_od_s = c_out;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] k038 [5];
    int n;
    logic saw_ir_low;
    k038 = '{32'd6, 32'd26, 32'd27, 32'd1, 32'd27};

    // Reset state
    #3;
    chk("rst_in_ready", a_in_ready, 1'b1);
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_out_data", a_out, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    chk("post_rst_in_ready", a_in_ready, 1'b1);

    // Fused 3*5+7, two-cycle latency; also the WIDTH=8 and 4-lane instances
    a_in_valid = 1; a_mode = 0; a_x = 3; a_y = 5; a_z = 7;
    b_in_valid = 1; b_mode = 0; b_x = 16; b_y = 16; b_z = 1;
    c_in_valid = 1; c_x = {16'd4, 16'd3, 16'd2, 16'd1};
    c_y = {4{16'd2}}; c_z = {16'd3, 16'd2, 16'd1, 16'd0};
    tick();
    a_in_valid = 0; c_in_valid = 0;
    b_mode = 1; b_clr = 1; b_x = 255; b_y = 255; b_z = 0;
    tick();
    b_in_valid = 0;
    chk("lat_not_early", a_ov_s, 1'b0);
    tick();
    chk("lat_valid", a_ov_s, 1'b1);
    chk("lat_data", a_od_s, 32'd22);
    chk("w8_fused_valid", b_ov_s, 1'b1);
    chk("w8_fused_wrap", b_od_s, 8'd1);
    chk("lanes4_valid", c_ov_s, 1'b1);
    chk("lanes4_data", c_od_s, {16'd11, 16'd8, 16'd5, 16'd2});
    tick();
    chk("w8_acc_valid", b_ov_s, 1'b1);
    chk("w8_acc_wrap", b_od_s, 8'd1);
    tick();

    // Accumulate sequence interleaved with a fused beat
    got.delete();
    a_in_valid = 1; a_mode = 1; a_clr = 1; a_x = 2; a_y = 3; a_z = 99; tick();
    a_clr = 0; a_x = 4; a_y = 5; tick();
    a_x = 1; a_y = 1; tick();
    a_mode = 0; a_x = 1; a_y = 1; a_z = 0; tick();
    a_mode = 1; a_x = 0; a_y = 0; a_z = 5; tick();
    a_in_valid = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("acc_seq_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk("acc_seq_val", got[i], k038[i]);

    // Backpressure: 5 fused beats, out_ready low on cycles 3..6
    got.delete(); n = 0; saw_ir_low = 0;
    for (int cyc = 0; cyc < 40 && (n < 5 || exp_q.size() != 0); cyc++) begin
      a_out_ready = !(cyc >= 3 && cyc <= 6);
      a_in_valid = (n < 5); a_mode = 0;
      a_x = $urandom; a_y = $urandom; a_z = $urandom;
      tick();
      if (!a_ir_s) saw_ir_low = 1;
      if (a_acc_s) n++;
    end
    a_in_valid = 0; a_out_ready = 1;
    chk("bp_accepted", n, 5);
    chk("bp_results", got.size(), 5);
    chk("bp_in_ready_low", saw_ir_low, 1'b1);
    chk("bp_drained", exp_q.size(), 0);

    // Random mixed traffic with random backpressure
    for (int cyc = 0; cyc < 300; cyc++) begin
      a_in_valid = $urandom_range(0, 1);
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_mode = $urandom_range(0, 1);
      a_clr = ($urandom_range(0, 3) == 0);
      a_x = $urandom; a_y = $urandom; a_z = $urandom;
      tick();
    end
    a_in_valid = 0; a_out_ready = 1;
    for (int i = 0; i < 6; i++) tick();
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_idle", a_busy, 1'b0);

    // Async reset with two beats in flight
    a_out_ready = 0; a_in_valid = 1; a_mode = 1; a_clr = 0; a_x = 9; a_y = 9; tick();
    a_x = 7; tick();
    a_in_valid = 0;
    #2;
    chk("inflight_busy", a_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", a_out_valid, 1'b0);
    chk("arst_busy", a_busy, 1'b0);
    chk("arst_out_data", a_out, 32'd0);
    chk("arst_in_ready", a_in_ready, 1'b1);
    exp_q.delete(); acc_m = 0; stall_prev = 0;
    @(posedge clk); #1; rst_n = 1'b1; a_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arst_no_result", a_ov_s, 1'b0);
    end
    // Accumulator was cleared: 0 + 1*1
    a_in_valid = 1; a_mode = 1; a_clr = 0; a_x = 1; a_y = 1; tick();
    a_in_valid = 0; tick(); tick();
    chk("arst_acc_valid", a_ov_s, 1'b1);
    chk("arst_acc_zero", a_od_s, 32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_add_stream.md
MUL_ADD_STREAM -- requirements
Module: mul_add_stream

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal 8..64).
REQ-002 Parameter: LANES, default 1, independent parallel lanes sharing one handshake (legal 1..8).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream beat offered.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 x  input  LANES*WIDTH  multiplicand, lane i at bits [i*WIDTH +: WIDTH].
REQ-008 y  input  LANES*WIDTH  multiplier, same packing.
REQ-009 z  input  LANES*WIDTH  addend, same packing.
REQ-010 mode  input  1  0 = fused (x*y+z), 1 = accumulate (acc+x*y, z ignored).
REQ-011 acc_clr  input  1  with mode=1: this beat's accumulation starts from 0.
REQ-012 out_valid  output  1  result beat offered.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 out_data  output  LANES*WIDTH  results, same packing.
REQ-015 busy  output  1  high while any pipeline stage holds a valid beat.

Function
REQ-016 Beat transfer on in_valid && in_ready; result transfer on out_valid && out_ready.
REQ-017 Two stages: S1 registers product (low WIDTH bits of x*y per lane), z, mode, acc_clr; S2 registers final result.
REQ-018 Latency: accepted beat appears on out_valid exactly 2 cycles later when out_ready held high.
REQ-019 Throughput: one beat per cycle sustained with out_ready high.
REQ-020 S2 loads when S1 valid and (S2 empty or S2 transferring out); S1 loads when (S1 empty or S1 moving to S2).
REQ-021 in_ready = S1 empty or S1 advancing this cycle; combinational from out_ready, no dependency on in_valid.
REQ-022 Backpressure: while out_valid && !out_ready, out_data and out_valid hold stable; at most 2 beats buffered, no loss, no duplication.
REQ-023 Mode 0 result per lane: (prod + z) mod 2^WIDTH; accumulator unchanged.
REQ-024 Mode 1 result per lane: acc_next = ((acc_clr ? 0 : acc) + prod) mod 2^WIDTH; acc updated and out_data = acc_next, at S2 load only.
REQ-025 Accumulator (one per lane) updates only on S2 load of a mode-1 beat; stalls never double-count.
REQ-026 Interleaved mode 0/1 beats permitted; mode-0 beats never disturb acc.
REQ-027 All arithmetic unsigned, overflow discarded silently, no flags.
REQ-028 Simultaneous out transfer and S1→S2 advance in same cycle: S2 replaced, no bubble.
REQ-029 busy = S1 valid or S2 valid.

Reset
REQ-030 On rst_n low, immediately (async): S1/S2 valid = 0, out_valid = 0, out_data = 0, acc = 0 all lanes, busy = 0.
REQ-031 in_ready = 1 during and after reset (both stages empty).
REQ-032 Reset mid-operation discards in-flight beats; no partial result emitted after deassertion.
REQ-033 Deassertion synchronised by the integrating system; block needs no reset synchroniser.

Structure
REQ-034 Package mul_add_stream_pkg holds mode encoding constants (MODE_FUSED=0, MODE_ACC=1) and lane-slice helper function.
REQ-035 One sub-module mul_add_stream_lane: per-lane multiply, add, accumulator; top holds handshake/valid control and generate loop over LANES.
REQ-036 Multiply written as behavioural operator, lint waiver around it.

Verification
REQ-037 WIDTH=32, LANES=1, mode=0, x=3 y=5 z=7, out_ready=1 -> out_data=22 two cycles after accept.
REQ-038 Mode=1: beats (2,3,clr=1),(4,5,0),(1,1,0) -> outputs 6, 26, 27; then mode=0 x=1 y=1 z=0 -> 1, acc stays 27.
REQ-039 Wrap: WIDTH=8, mode=0, x=16 y=16 z=1 -> out_data=1; mode=1 clr x=255 y=255 -> 1.
REQ-040 Backpressure: stream 5 fused beats, out_ready low cycles 3-6 -> in_ready low after 2 buffered, all 5 results in order, held stable while stalled.
REQ-041 LANES=4, WIDTH=16, lane i x=i+1 y=2 z=i -> lanes {2,5,8,11}.
REQ-042 Async reset asserted with 2 beats in flight -> out_valid/busy 0 immediately, acc 0, no result after release.
